bayer_window_3x3: RTL and testbench

Downstream neighbour of the Bayer address generator. It consumes the raster-order pixel stream read from image memory at the generated addresses and buffers two full lines in on-chip RAM. It emits one zero-padded 3x3 neighbourhood per image pixel, tagged with the centre row, column and Bayer symbol, for the demosaicing/interpolation stage. It also generates its own flush cycles after the last input pixel, so every pixel gets a window.

---
 rtl/bayer_window_3x3.sv | 160 ++++++++++++++++
 tb/tb_bayer_window_3x3.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_window_3x3.sv
// Raster-stream 3x3 neighbourhood generator with two line buffers, zero-padded borders
// and self-generated flush cycles so that every pixel gets a window.
module bayer_window_3x3 #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_COLS = 2048,
    parameter int unsigned IDX_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IDX_W-1:0]      rowMax,
    input  logic [IDX_W-1:0]      colMax,
    input  logic [1:0]            patternSelect,
    input  logic [DATA_W-1:0]     pixelIn,
    input  logic                  pixelValid,
    output logic                  ready,
    output logic [9*DATA_W-1:0]   window,
    output logic                  windowValid,
    output logic [IDX_W-1:0]      centerRow,
    output logic [IDX_W-1:0]      centerCol,
    output logic [1:0]            centerSymbol,
    output logic                  done
);

    localparam int unsigned ADDR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned COL_W  = 3 * DATA_W;

    typedef enum logic [1:0] {IDLE, ACCEPT, FLUSH, DONE} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     row_max_q, col_max_q;
    logic [1:0]           pattern_q;
    logic [IDX_W-1:0]     in_row, in_col, ctr_row, ctr_col;
    logic [CNT_W-1:0]     flush_cnt;
    logic                 primed;
    logic [DATA_W-1:0]    lb0 [MAX_COLS];
    logic [DATA_W-1:0]    lb1 [MAX_COLS];
    logic [ADDR_W-1:0]    lb_addr;
    logic [COL_W-1:0]     col_q1, col_q2, col_new;
    logic [9*DATA_W-1:0]  win_c;
    logic                 advance, emit, last_pixel, flush_last;
    logic [DATA_W-1:0]    pix;

    assign lb_addr    = ADDR_W'(in_col);
    // Column vector: bits [0] = row r-2, [1] = row r-1, [2] = incoming row r.
    assign col_new    = {pix, lb0[lb_addr], lb1[lb_addr]};
    assign last_pixel = (in_row == row_max_q) && (in_col == col_max_q);
    assign flush_last = (flush_cnt == ({1'b0, col_max_q} + CNT_W'(1)));
    assign emit       = advance && (primed || ((in_row == IDX_W'(1)) && (in_col == IDX_W'(1))));

    // Next state and per-cycle pipeline advance; flush cycles inject zero pixels.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        pix        = '0;
        case (state)
            IDLE:   if (start) state_next = ACCEPT;
            ACCEPT: if (pixelValid) begin
                advance = 1'b1;
                pix     = pixelIn;
                if (last_pixel) state_next = FLUSH;
            end
            FLUSH: begin
                advance = 1'b1;
                if (flush_last) state_next = DONE;
            end
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tap selection with border masking relative to the centre coordinate.
    always_comb begin
        win_c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                logic [COL_W-1:0] src;
                logic             off;
                src = (j == 0) ? col_q2 : ((j == 1) ? col_q1 : col_new);
                off = ((i == 0) && (ctr_row == '0)) || ((i == 2) && (ctr_row == row_max_q)) ||
                      ((j == 0) && (ctr_col == '0)) || ((j == 2) && (ctr_col == col_max_q));
                if (!off) win_c[(3*i+j)*DATA_W +: DATA_W] = src[i*DATA_W +: DATA_W];
            end
        end
    end

    // Line buffers need no reset: stale contents only ever land in masked taps.
    always_ff @(posedge clk) begin
        if (advance) begin
            lb1[lb_addr] <= lb0[lb_addr];
            lb0[lb_addr] <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ready        <= 1'b0;
            done         <= 1'b0;
            windowValid  <= 1'b0;
            window       <= '0;
            centerRow    <= '0;
            centerCol    <= '0;
            centerSymbol <= '0;
            row_max_q    <= '0;
            col_max_q    <= '0;
            pattern_q    <= '0;
            in_row       <= '0;
            in_col       <= '0;
            ctr_row      <= '0;
            ctr_col      <= '0;
            flush_cnt    <= '0;
            primed       <= 1'b0;
            col_q1       <= '0;
            col_q2       <= '0;
        end else begin
            state       <= state_next;
            ready       <= (state_next == ACCEPT);
            done        <= (state == DONE);
            windowValid <= emit;
            if (state == IDLE && start) begin
                row_max_q <= rowMax;
                col_max_q <= colMax;
                pattern_q <= patternSelect;
                in_row    <= '0;
                in_col    <= '0;
                ctr_row   <= '0;
                ctr_col   <= '0;
                flush_cnt <= '0;
                primed    <= 1'b0;
            end
            if (advance) begin
                col_q2 <= col_q1;
                col_q1 <= col_new;
                if (in_col == col_max_q) begin
                    in_col <= '0;
                    in_row <= (in_row == row_max_q) ? '0 : in_row + IDX_W'(1);
                end else begin
                    in_col <= in_col + IDX_W'(1);
                end
                if (state == FLUSH) flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (emit) begin
                primed       <= 1'b1;
                window       <= win_c;
                centerRow    <= ctr_row;
                centerCol    <= ctr_col;
                centerSymbol <= pattern_q ^ {ctr_row[0], ctr_col[0]};
                if (ctr_col == col_max_q) begin
                    ctr_col <= '0;
                    ctr_row <= (ctr_row == row_max_q) ? '0 : ctr_row + IDX_W'(1);
                end else begin
                    ctr_col <= ctr_col + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bayer_window_3x3.sv
// Scoreboarded bench for bayer_window_3x3: zero-padded reference windows per frame,
// plus a table of hand-derived taps and symbols checked after the runs.
module tb_bayer_window_3x3;

    localparam int DW = 8;
    localparam int IW = 11;

    logic          clk = 1'b0;
    logic          rst, start, pixelValid;
    logic [IW-1:0] rowMax, colMax;
    logic [1:0]    patternSelect;
    logic [DW-1:0] pixelIn;
    logic          ready, windowValid, done;
    logic [9*DW-1:0] window;
    logic [IW-1:0] centerRow, centerCol;
    logic [1:0]    centerSymbol;

    bayer_window_3x3 #(.DATA_W(DW), .MAX_COLS(64), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .rowMax(rowMax), .colMax(colMax),
        .patternSelect(patternSelect), .pixelIn(pixelIn), .pixelValid(pixelValid),
        .ready(ready), .window(window), .windowValid(windowValid),
        .centerRow(centerRow), .centerCol(centerCol), .centerSymbol(centerSymbol),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        logic [IW-1:0] row;
        logic [IW-1:0] col;
        logic [1:0]  sym;
    } exp_t;

    typedef struct {
        int          scen;
        int          idx;
        logic        chk_win;
        logic [71:0] win;
        logic [1:0]  sym;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wv_cnt = 0;
    int          first_wv = -1;
    int          acc_cyc = -1;
    int          cur_scen = 0;
    int          img[64];
    logic [71:0] cap_win[5][64];
    logic [1:0]  cap_sym[5][64];
    logic        prev_stall = 1'b0;
    vec_t        tbl[12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic exp_t model(input int r, input int c, input int rm, input int cm, input int ps);
        exp_t m;
        m.win = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int rr = r + i - 1;
                int cc = c + j - 1;
                if (rr >= 0 && rr <= rm && cc >= 0 && cc <= cm)
                    m.win[(3*i+j)*8 +: 8] = 8'(img[rr*(cm+1)+cc]);
            end
        m.row = IW'(r);
        m.col = IW'(c);
        m.sym = 2'(ps ^ (((r & 1) << 1) | (c & 1)));
        return m;
    endfunction

    // Output monitor: every strobe pops one expected window.
    always @(negedge clk) begin
        if (windowValid === 1'b1) begin
            chk("wv_after_stall", 72'(prev_stall), 72'(0));
            if (sb.size() == 0) begin
                chk("sb_underflow", 72'(sb.size()), 72'(1));
            end else begin
                e = sb.pop_front();
                chk("window", window, e.win);
                chk("centerRow", 72'(centerRow), 72'(e.row));
                chk("centerCol", 72'(centerCol), 72'(e.col));
                chk("centerSymbol", 72'(centerSymbol), 72'(e.sym));
            end
            if (wv_cnt < 64) begin
                cap_win[cur_scen][wv_cnt] = window;
                cap_sym[cur_scen][wv_cnt] = centerSymbol;
            end
            if (wv_cnt == 0) first_wv = cyc;
            wv_cnt++;
        end
        prev_stall = (ready === 1'b1) && (pixelValid !== 1'b1);
    end

    task automatic run_frame(input int rm, input int cm, input int ps, input int off,
                             input bit gaps, input int stop_after, input int scen);
        int n, lim, k, t, budget, pre;
        logic [3:0] gap_pat;
        gap_pat = 4'b1001;
        n = (rm + 1) * (cm + 1);
        lim = (stop_after >= 0) ? stop_after : n;
        for (int i = 0; i < n; i++) img[i] = (i + off) & 255;
        sb.delete();
        for (int r = 0; r <= rm; r++)
            for (int c = 0; c <= cm; c++) sb.push_back(model(r, c, rm, cm, ps));
        wv_cnt = 0; cur_scen = scen; first_wv = -1; acc_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; rowMax = IW'(rm); colMax = IW'(cm); patternSelect = 2'(ps);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; t = 0; budget = 0;
        while (k < lim && budget < 2000) begin
            pixelValid = gaps ? gap_pat[t % 4] : 1'b1;
            pixelIn = 8'(img[k]);
            t++;
            @(negedge clk);
            if (ready === 1'b1 && pixelValid) begin
                if (k == cm + 2) acc_cyc = cyc;
                k++;
            end
            @(posedge clk); #1;
            budget++;
        end
        pixelValid = 1'b0;
        chk("accept_count", 72'(k), 72'(lim));
        if (stop_after < 0) begin
            pre = 0;
            budget = 0;
            @(negedge clk);
            while (done !== 1'b1 && budget < 200) begin
                chk("ready_low_after_input", 72'(ready), 72'(0));
                pre++; budget++;
                @(negedge clk);
            end
            chk("done_seen", 72'(done), 72'(1));
            chk("cycles_to_done", 72'(pre), 72'(cm + 3));
            chk("window_count", 72'(wv_cnt), 72'(n));
            chk("sb_empty", 72'(sb.size()), 72'(0));
            chk("first_wv_latency", 72'(first_wv), 72'(acc_cyc + 1));
            @(negedge clk);
            chk("done_one_cycle", 72'(done), 72'(0));
            chk("ready_idle", 72'(ready), 72'(0));
        end
    endtask

    initial begin
        tbl[0]  = '{0, 0,  1'b1, mk(0,0,0, 0,0,1, 0,4,5), 2'd0};
        tbl[1]  = '{0, 5,  1'b1, mk(0,1,2, 4,5,6, 8,9,10), 2'd0};
        tbl[2]  = '{0, 15, 1'b1, mk(10,11,0, 14,15,0, 0,0,0), 2'd0};
        tbl[3]  = '{3, 0,  1'b1, mk(0,0,0, 0,0,1, 0,4,5), 2'd0};
        tbl[4]  = '{3, 5,  1'b1, mk(0,1,2, 4,5,6, 8,9,10), 2'd0};
        tbl[5]  = '{3, 15, 1'b1, mk(10,11,0, 14,15,0, 0,0,0), 2'd0};
        tbl[6]  = '{1, 3,  1'b1, mk(1,2,0, 3,4,0, 0,0,0), 2'd0};
        tbl[7]  = '{2, 0,  1'b0, '0, 2'd3};
        tbl[8]  = '{2, 1,  1'b0, '0, 2'd2};
        tbl[9]  = '{2, 8,  1'b0, '0, 2'd1};
        tbl[10] = '{2, 9,  1'b0, '0, 2'd0};
        tbl[11] = '{2, 18, 1'b0, '0, 2'd3};

        rst = 1'b1; start = 1'b0; pixelValid = 1'b0; pixelIn = '0;
        rowMax = '0; colMax = '0; patternSelect = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 72'(ready), 72'(0));
        chk("rst_wv", 72'(windowValid), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        chk("rst_window", window, 72'(0));
        chk("rst_row", 72'(centerRow), 72'(0));
        chk("rst_col", 72'(centerCol), 72'(0));
        chk("rst_sym", 72'(centerSymbol), 72'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(3, 3, 0, 0, 1'b0, -1, 0);
        run_frame(7, 7, 0, 0, 1'b1, -1, 4);
        run_frame(7, 7, 3, 0, 1'b0, -1, 2);

        // Abort an 8x8 frame after 20 accepted pixels.
        run_frame(7, 7, 0, 0, 1'b0, 20, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_rst_ready", 72'(ready), 72'(0));
        chk("post_rst_wv", 72'(windowValid), 72'(0));
        chk("post_rst_done", 72'(done), 72'(0));
        repeat (5) @(negedge clk);
        chk("post_rst_no_windows", 72'(sb.size()), 72'(0));

        run_frame(3, 3, 0, 0, 1'b0, -1, 3);
        run_frame(1, 1, 0, 1, 1'b0, -1, 1);

        for (int v = 0; v < 12; v++) begin
            if (tbl[v].chk_win)
                chk($sformatf("tbl_win[%0d]", v), cap_win[tbl[v].scen][tbl[v].idx], tbl[v].win);
            else
                chk($sformatf("tbl_sym[%0d]", v), 72'(cap_sym[tbl[v].scen][tbl[v].idx]), 72'(tbl[v].sym));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
